// File: rtl/filtro_mac.sv
// filtro_mac: sequential FIR filter built around one shared multiply-accumulate.
// An accepted sample is shifted into the delay line, and then one tap is
// accumulated per clock. TAPS clocks later, Datos_Sum is loaded and
// Out_Valid pulses for one cycle.
// Optional feature: define FILTRO_MAC_SAT_EN to make the accumulator saturate
// instead of wrapping. In that build Acc_Sat is a sticky clamp flag.
module filtro_mac #(
   parameter int unsigned N    = 25,
   parameter int unsigned TAPS = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic signed [N-1:0]       Dato_In,
   input  logic                      In_Valid,
   input  logic                      Coef_We,
   input  logic [$clog2(TAPS)-1:0]   Coef_Addr,
   input  logic signed [N-1:0]       Coef_Dato,
   output logic signed [2*N-1:0]     Datos_Sum,
   output logic                      Out_Valid,
   output logic                      Busy,
   output logic                      Overrun,
   output logic                      Acc_Sat
);

   localparam int unsigned AW = $clog2(TAPS);
   localparam int unsigned NW = 2 * N;

   typedef enum logic {IDLE, MAC} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic signed [N-1:0]   r_x [TAPS];
   logic signed [N-1:0]   r_c [TAPS];
   logic signed [NW-1:0]  r_acc;
   logic [AW-1:0]         r_idx;
   logic signed [NW-1:0]  w_prod;
   logic signed [NW-1:0]  w_acc_nxt;
   logic                  w_accept;
   logic                  w_drop;
   logic                  w_last;
   logic                  w_coef_wr;

   // Next-state and control strobes
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_drop      = 1'b0;
      w_last      = 1'b0;
      w_coef_wr   = 1'b0;
      case (r_state)
         IDLE: begin
            w_accept  = In_Valid;
            w_coef_wr = Coef_We && ({1'b0, Coef_Addr} < (AW+1)'(TAPS));
            if (In_Valid) w_state_nxt = MAC;
         end
         MAC: begin
            w_drop = In_Valid;
            if (r_idx == AW'(TAPS - 1)) begin
               w_last      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register, with Busy tracking the MAC state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         Busy    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         Busy    <= (w_state_nxt == MAC);
      end
   end

   // Full-precision product of the current tap, computed after sign extension
   assign w_prod = NW'(r_x[r_idx]) * NW'(r_c[r_idx]);

`ifdef FILTRO_MAC_SAT_EN
   localparam logic signed [NW-1:0] ACC_MAX = {1'b0, {(NW-1){1'b1}}};
   localparam logic signed [NW-1:0] ACC_MIN = {1'b1, {(NW-1){1'b0}}};

   logic signed [NW:0] w_sum_ext;
   logic               w_ovf;

   assign w_sum_ext = (NW+1)'(r_acc) + (NW+1)'(w_prod);
   assign w_ovf     = w_sum_ext[NW] ^ w_sum_ext[NW-1];

   // Clamp toward the sign of the true sum on overflow
   always_comb begin
      w_acc_nxt = w_sum_ext[NW-1:0];
      if (w_ovf) w_acc_nxt = w_sum_ext[NW] ? ACC_MIN : ACC_MAX;
   end

   // Sticky record of any clamp
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        Acc_Sat <= 1'b0;
      else if (r_state == MAC && w_ovf) Acc_Sat <= 1'b1;
   end
`else
   assign w_acc_nxt = r_acc + w_prod;
   assign Acc_Sat   = 1'b0;
`endif

   // Delay line, coefficients, accumulator and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < int'(TAPS); k++) begin
            r_x[k] <= '0;
            r_c[k] <= '0;
         end
         r_acc     <= '0;
         r_idx     <= '0;
         Datos_Sum <= '0;
         Out_Valid <= 1'b0;
         Overrun   <= 1'b0;
      end else begin
         Out_Valid <= w_last;
         if (w_coef_wr) r_c[Coef_Addr] <= Coef_Dato;
         if (w_accept) begin
            r_x[0] <= Dato_In;
            for (int k = 1; k < int'(TAPS); k++) r_x[k] <= r_x[k-1];
            r_acc <= '0;
            r_idx <= '0;
         end else if (r_state == MAC) begin
            r_acc <= w_acc_nxt;
            r_idx <= w_last ? '0 : r_idx + 1'b1;
         end
         if (w_last) Datos_Sum <= w_acc_nxt;
         if (w_drop) Overrun   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_filtro_mac.sv
// Directed bench for filtro_mac (N=25, TAPS=8) with hand-computed expectations.
module tb_filtro_mac;

   localparam int unsigned N    = 25;
   localparam int unsigned TAPS = 8;
   localparam int unsigned AW   = $clog2(TAPS);
   localparam int unsigned NW   = 2 * N;

   logic                 clk;
   logic                 reset;
   logic signed [N-1:0]  Dato_In;
   logic                 In_Valid;
   logic                 Coef_We;
   logic [AW-1:0]        Coef_Addr;
   logic signed [N-1:0]  Coef_Dato;
   logic signed [NW-1:0] Datos_Sum;
   logic                 Out_Valid;
   logic                 Busy;
   logic                 Overrun;
   logic                 Acc_Sat;

   int vectors     = 0;
   int miscompares = 0;

   filtro_mac #(.N(N), .TAPS(TAPS)) dut (
      .clk       (clk),
      .reset     (reset),
      .Dato_In   (Dato_In),
      .In_Valid  (In_Valid),
      .Coef_We   (Coef_We),
      .Coef_Addr (Coef_Addr),
      .Coef_Dato (Coef_Dato),
      .Datos_Sum (Datos_Sum),
      .Out_Valid (Out_Valid),
      .Busy      (Busy),
      .Overrun   (Overrun),
      .Acc_Sat   (Acc_Sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic write_coef(input int a, input logic signed [N-1:0] v);
      Coef_We   = 1'b1;
      Coef_Addr = AW'(a);
      Coef_Dato = v;
      tick();
      Coef_We   = 1'b0;
   endtask

   task automatic send(input logic signed [N-1:0] s);
      In_Valid = 1'b1;
      Dato_In  = s;
      tick();
      In_Valid = 1'b0;
   endtask

   // Counts edges until Out_Valid, bounded, and checks the count
   task automatic wait_out(input string tag, input int exp_lat);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!Out_Valid && n < 20);
      chk(tag, NW'(n), NW'(exp_lat));
   endtask

   initial begin
      logic signed [NW-1:0] e;
      logic                 seen;
      reset     = 1'b1;
      Dato_In   = '0;
      In_Valid  = 1'b0;
      Coef_We   = 1'b0;
      Coef_Addr = '0;
      Coef_Dato = '0;
      #1;
      chk("rst_sum",  Datos_Sum, '0);
      chk("rst_ov",   NW'(Out_Valid), '0);
      chk("rst_busy", NW'(Busy), '0);
      chk("rst_ovr",  NW'(Overrun), '0);
      chk("rst_sat",  NW'(Acc_Sat), '0);
      tick();
      reset = 1'b0;

      // Identity tap: c[0]=1, one sample of 5
      write_coef(0, 25'sd1);
      send(25'sd5);
      chk("id_busy", NW'(Busy), 1);
      wait_out("id_lat", 8);
      chk("id_sum", Datos_Sum, 5);
      tick();
      chk("id_pulse", NW'(Out_Valid), 0);
      chk("id_hold",  Datos_Sum, 5);
      chk("id_idle",  NW'(Busy), 0);

      // Negative coefficient: -3 * 7
      do_reset();
      write_coef(0, -25'sd3);
      send(25'sd7);
      wait_out("neg_lat", 8);
      e = -50'sd21;
      chk("neg_sum",  Datos_Sum, e);
      chk("neg_sign", NW'(Datos_Sum[NW-1]), 1);

      // All coefficients 2, samples 1..8 back-to-back (each accepted in the Out_Valid cycle)
      do_reset();
      for (int a = 0; a < int'(TAPS); a++) write_coef(a, 25'sd2);
      for (int k = 1; k <= 8; k++) begin
         send(N'(k));
         wait_out($sformatf("ramp_lat%0d", k), 8);
         if (k == 4 || k == 8) chk($sformatf("ramp_sum%0d", k), Datos_Sum, NW'(k * (k + 1)));
      end
      chk("ramp_ovr", NW'(Overrun), 0);

      // Sample dropped while busy; coefficient write while busy ignored
      do_reset();
      write_coef(0, 25'sd1);
      write_coef(1, 25'sd10);
      send(25'sd4);
      Coef_We = 1'b1; Coef_Addr = '0; Coef_Dato = 25'sd100;
      tick();
      Coef_We = 1'b0;
      tick();
      In_Valid = 1'b1; Dato_In = 25'sd9;
      tick();
      In_Valid = 1'b0;
      chk("drop_ovr", NW'(Overrun), 1);
      wait_out("drop_lat", 5);
      chk("drop_sum", Datos_Sum, 4);
      send(25'sd6);
      wait_out("drop2_lat", 8);
      chk("drop2_sum", Datos_Sum, 46);
      chk("drop2_ovr", NW'(Overrun), 1);

      // Reset 4 cycles into MAC aborts the sequence
      send(25'sd5);
      repeat (4) tick();
      reset = 1'b1;
      #1;
      chk("abort_sum",  Datos_Sum, '0);
      chk("abort_ov",   NW'(Out_Valid), 0);
      chk("abort_busy", NW'(Busy), 0);
      chk("abort_ovr",  NW'(Overrun), 0);
      tick();
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (Out_Valid) seen = 1'b1;
      end
      chk("abort_nopulse", NW'(seen), 0);
      write_coef(0, 25'sd1);
      write_coef(1, 25'sd2);
      send(25'sd9);
      wait_out("abort_next_lat", 8);
      chk("abort_next_sum", Datos_Sum, 9);

      // Coefficient write and sample in the same IDLE cycle
      do_reset();
      Coef_We = 1'b1; Coef_Addr = '0; Coef_Dato = 25'sd3;
      send(25'sd5);
      Coef_We = 1'b0;
      wait_out("same_lat", 8);
      chk("same_sum", Datos_Sum, 15);

      // Accumulator overflow: two products of 2^48
      do_reset();
      write_coef(0, -25'sd16777216);
      write_coef(1, -25'sd16777216);
      send(-25'sd16777216);
      wait_out("ovf1_lat", 8);
      e = 50'sd1 <<< 48;
      chk("ovf1_sum", Datos_Sum, e);
      send(-25'sd16777216);
      wait_out("ovf2_lat", 8);
`ifdef FILTRO_MAC_SAT_EN
      e = {1'b0, {(NW-1){1'b1}}};
      chk("ovf2_sum", Datos_Sum, e);
      chk("ovf2_sat", NW'(Acc_Sat), 1);
`else
      e = {1'b1, {(NW-1){1'b0}}};
      chk("ovf2_sum", Datos_Sum, e);
      chk("ovf2_sat", NW'(Acc_Sat), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
